// File: rtl/vga_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_pkg                                                              |
// | Shared display geometry, frame-buffer sizing and grant encoding.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package vga_pkg;

  localparam int H_DISP      = 640;
  localparam int V_DISP      = 480;
  localparam int SCALE_SHIFT = 2;
  localparam int ADDR_W      = 15;
  localparam int DATA_W      = 8;

  localparam int FB_W    = H_DISP >> SCALE_SHIFT;
  localparam int FB_H    = V_DISP >> SCALE_SHIFT;
  localparam int FB_SIZE = FB_W * FB_H;

  // RGB332 pixel
  typedef logic [DATA_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } grant_e;

endpackage
`default_nettype wire

// File: rtl/vga_fb_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_fb_arbiter_if                                                    |
// | Writer handshake and frame-buffer RAM port bundle.                   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface vga_fb_arbiter_if #(
  parameter int ADDR_W = vga_pkg::ADDR_W,
  parameter int DATA_W = vga_pkg::DATA_W
) ();

  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic              wr_err;
  logic              err_clr;
  logic              vblank_only;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side: owns the RAM port and answers the writer
  modport master (
    input  wr_req, wr_addr, wr_data, err_clr, vblank_only, mem_rdata,
    output wr_ack, wr_err, mem_en, mem_we, mem_addr, mem_wdata
  );

  // Environment side: the pixel writer plus the RAM
  modport slave (
    output wr_req, wr_addr, wr_data, err_clr, vblank_only, mem_rdata,
    input  wr_ack, wr_err, mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface
`default_nettype wire

// File: rtl/vga_fb_addr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_fb_addr_gen                                                      |
// | Maps screen (x,y) to a down-scaled frame-buffer address, shift-add.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module vga_fb_addr_gen #(
  parameter int ADDR_W = vga_pkg::ADDR_W
) (
  input  logic [9:0]        i_pixel_x,
  input  logic [9:0]        i_pixel_y,
  output logic [ADDR_W-1:0] o_rd_addr
);
  import vga_pkg::*;

  localparam logic [15:0] c_fb_w_bits = 16'(FB_W);

  logic [ADDR_W-1:0] w_x_s;
  logic [ADDR_W-1:0] w_y_s;
  logic [ADDR_W-1:0] w_row_base;

  assign w_x_s = ADDR_W'(i_pixel_x >> SCALE_SHIFT);
  assign w_y_s = ADDR_W'(i_pixel_y >> SCALE_SHIFT);

  // y*FB_W as a sum of shifted copies of y, one per set bit of FB_W
  always_comb begin
    w_row_base = '0;
    for (int k = 0; k < 16; k++) begin
      if (c_fb_w_bits[k]) begin
        w_row_base = w_row_base + (w_y_s << k);
      end
    end
  end

  assign o_rd_addr = w_row_base + w_x_s;

endmodule
`default_nettype wire

// File: rtl/vga_fb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_fb_arbiter                                                       |
// | Shares one frame-buffer RAM between VGA scan-out and a pixel writer. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module vga_fb_arbiter #(
  parameter int ADDR_W = vga_pkg::ADDR_W,
  parameter int DATA_W = vga_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              p_tick,
  input  logic              video_on_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  vga_fb_arbiter_if.master  bus,
  output logic [DATA_W-1:0] rgb,
  output logic              hsync,
  output logic              vsync,
  output logic              video_on
);
  import vga_pkg::*;

  localparam logic [9:0]        c_v_disp  = 10'(V_DISP);
  localparam logic [ADDR_W-1:0] c_fb_size = ADDR_W'(FB_SIZE);

  grant_e            w_grant;
  logic [ADDR_W-1:0] w_rd_addr;
  logic              w_wr_oor;

  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_wr_ack;
  logic              r_wr_err;
  logic [1:0]        r_hs_pipe;
  logic [1:0]        r_vs_pipe;
  logic [1:0]        r_von_pipe;
  logic [1:0]        r_rd_pipe;
  logic [DATA_W-1:0] r_rgb_hold;

  vga_fb_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .i_pixel_x (pixel_x),
    .i_pixel_y (pixel_y),
    .o_rd_addr (w_rd_addr)
  );

  assign w_wr_oor = (bus.wr_addr >= c_fb_size);

  // Scan-out has absolute priority; r_wr_ack stops a request being granted twice
  always_comb begin
    w_grant = IDLE;
    if (p_tick && video_on_in) begin
      w_grant = RD;
    end else if (bus.wr_req && !r_wr_ack &&
                 (!bus.vblank_only || (pixel_y >= c_v_disp))) begin
      w_grant = WR;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_wr_ack    <= 1'b0;
      r_wr_err    <= 1'b0;
    end else begin
      r_mem_en <= 1'b0;
      r_mem_we <= 1'b0;
      r_wr_ack <= (w_grant == WR);
      case (w_grant)
        RD: begin
          r_mem_en   <= 1'b1;
          r_mem_addr <= w_rd_addr;
        end
        WR: begin
          if (!w_wr_oor) begin
            r_mem_en    <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= bus.wr_addr;
            r_mem_wdata <= bus.wr_data;
          end
        end
        default: ;
      endcase
      if ((w_grant == WR) && w_wr_oor) begin
        r_wr_err <= 1'b1;
      end else if (bus.err_clr) begin
        r_wr_err <= 1'b0;
      end
    end
  end

  // Two-stage alignment: one clk to the registered RAM port, one clk of RAM latency
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hs_pipe  <= '0;
      r_vs_pipe  <= '0;
      r_von_pipe <= '0;
      r_rd_pipe  <= '0;
      r_rgb_hold <= '0;
    end else begin
      r_hs_pipe  <= {r_hs_pipe[0], hsync_in};
      r_vs_pipe  <= {r_vs_pipe[0], vsync_in};
      r_von_pipe <= {r_von_pipe[0], video_on_in};
      r_rd_pipe  <= {r_rd_pipe[0], (w_grant == RD)};
      if (r_rd_pipe[1]) begin
        r_rgb_hold <= bus.mem_rdata;
      end
    end
  end

  // Fresh RAM data on the cycle it arrives, held copy on the following non-tick cycle
  always_comb begin
    rgb = '0;
    if (r_von_pipe[1]) begin
      rgb = r_rd_pipe[1] ? bus.mem_rdata : r_rgb_hold;
    end
  end

  assign hsync         = r_hs_pipe[1];
  assign vsync         = r_vs_pipe[1];
  assign video_on      = r_von_pipe[1];
  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.wr_ack    = r_wr_ack;
  assign bus.wr_err    = r_wr_err;

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_vga_fb_arbiter                                                    |
// | Directed self-checking bench with a behavioural frame-buffer RAM.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_vga_fb_arbiter;

  logic       clk         = 1'b0;
  logic       reset_n     = 1'b0;
  logic       p_tick      = 1'b0;
  logic       video_on_in = 1'b0;
  logic       hsync_in    = 1'b0;
  logic       vsync_in    = 1'b0;
  logic [9:0] pixel_x     = '0;
  logic [9:0] pixel_y     = '0;
  logic [7:0] rgb;
  logic       hsync;
  logic       vsync;
  logic       video_on;

  int n_tests = 0;
  int n_fail  = 0;

  vga_fb_arbiter_if #(.ADDR_W(15), .DATA_W(8)) bus ();

  vga_fb_arbiter #(
    .ADDR_W (15),
    .DATA_W (8)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .p_tick      (p_tick),
    .video_on_in (video_on_in),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .bus         (bus),
    .rgb         (rgb),
    .hsync       (hsync),
    .vsync       (vsync),
    .video_on    (video_on)
  );

  always #10 clk = ~clk;

  // Unwritten locations read back as the low byte of their address
  logic [7:0] ram  [0:32767];
  logic       wvld [0:32767];
  logic [14:0] ram_a;
  assign ram_a = bus.mem_addr;

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        ram[ram_a]  <= bus.mem_wdata;
        wvld[ram_a] <= 1'b1;
      end else begin
        bus.mem_rdata <= wvld[ram_a] ? ram[ram_a] : ram_a[7:0];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] flags();
    return 32'({bus.mem_en, bus.mem_we, bus.wr_ack, bus.wr_err, hsync, vsync, video_on});
  endfunction

  logic [14:0] a_tab [3] = '{15'd100, 15'd200, 15'd300};
  logic [7:0]  d_tab [3] = '{8'hA1, 8'hB2, 8'hC3};
  int          acks;

  initial begin
    bus.wr_req      = 1'b0;
    bus.wr_addr     = '0;
    bus.wr_data     = '0;
    bus.err_clr     = 1'b0;
    bus.vblank_only = 1'b0;

    // Power-on reset
    repeat (2) step();
    check("rst_flags", flags(), 0);
    check("rst_rgb",   32'(rgb), 0);
    check("rst_addr",  32'(bus.mem_addr), 0);
    check("rst_wdata", 32'(bus.mem_wdata), 0);

    // Activity mid-frame, then asynchronous reset between edges
    reset_n = 1'b1;
    hsync_in = 1'b1; vsync_in = 1'b1; video_on_in = 1'b1; p_tick = 1'b1;
    pixel_x = 10'd8; pixel_y = 10'd4;
    repeat (3) step();
    check("pre_rst_active", 32'({bus.mem_en, hsync, vsync, video_on}), 'hF);
    #4 reset_n = 1'b0;
    #1;
    check("async_flags", flags(), 0);
    check("async_rgb",   32'(rgb), 0);
    check("async_addr",  32'(bus.mem_addr), 0);
    step();
    reset_n = 1'b1;
    hsync_in = 1'b0; vsync_in = 1'b0; video_on_in = 1'b0; p_tick = 1'b0;
    repeat (2) step();

    // Scan-out: (8,4) -> 162, (12,4) -> 163
    p_tick = 1'b1; video_on_in = 1'b1; hsync_in = 1'b1; vsync_in = 1'b0;
    pixel_x = 10'd8; pixel_y = 10'd4;
    step();
    check("rd_en",     32'({bus.mem_en, bus.mem_we}), 'b10);
    check("rd_addr",   32'(bus.mem_addr), 162);
    check("rd_hs_d1",  32'(hsync), 0);
    p_tick = 1'b0; hsync_in = 1'b0; vsync_in = 1'b1;
    step();
    check("rd_rgb",    32'(rgb), 'hA2);
    check("rd_sync_d2", 32'({hsync, vsync, video_on}), 'b101);
    p_tick = 1'b1; pixel_x = 10'd12; vsync_in = 1'b0;
    step();
    check("rd_hold",   32'(rgb), 'hA2);
    check("rd_vs_d2",  32'(vsync), 1);
    check("rd_addr2",  32'(bus.mem_addr), 163);
    p_tick = 1'b0;
    step();
    check("rd_rgb2",   32'(rgb), 'hA3);
    video_on_in = 1'b0;
    repeat (2) step();
    check("blank_rgb", 32'({video_on, rgb}), 0);

    // Contention during active video: (16,8) -> 324, (20,8) -> 325
    video_on_in = 1'b1; p_tick = 1'b1; pixel_x = 10'd16; pixel_y = 10'd8;
    bus.wr_req = 1'b1; bus.wr_addr = 15'd500; bus.wr_data = 8'h5A;
    step();
    check("cont_no_wr",  32'({bus.wr_ack, bus.mem_we}), 0);
    check("cont_rdaddr", 32'(bus.mem_addr), 324);
    p_tick = 1'b0;
    step();
    check("cont_ack",    32'({bus.wr_ack, bus.mem_en, bus.mem_we}), 'b111);
    check("cont_waddr",  32'(bus.mem_addr), 500);
    check("cont_wdata",  32'(bus.mem_wdata), 'h5A);
    check("cont_rgb",    32'(rgb), 'h44);
    bus.wr_req = 1'b0; p_tick = 1'b1; pixel_x = 10'd20;
    step();
    check("cont_ack_pulse", 32'(bus.wr_ack), 0);
    check("cont_rgb_hold",  32'(rgb), 'h44);
    check("cont_ram",       32'(ram[500]), 'h5A);
    p_tick = 1'b0;
    step();
    check("cont_rgb2",   32'(rgb), 'h45);
    video_on_in = 1'b0;
    step();

    // vblank_only: no grant before line 480
    bus.vblank_only = 1'b1; pixel_y = 10'd100;
    bus.wr_req = 1'b1; bus.wr_addr = 15'd1000; bus.wr_data = 8'h3C;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      p_tick = ~p_tick;
      step();
      if (bus.wr_ack) acks++;
    end
    pixel_y = 10'd479;
    step();
    if (bus.wr_ack) acks++;
    check("vb_no_ack", 32'(acks), 0);
    pixel_y = 10'd480;
    step();
    check("vb_ack",   32'({bus.wr_ack, bus.mem_en, bus.mem_we}), 'b111);
    check("vb_addr",  32'(bus.mem_addr), 1000);
    check("vb_wdata", 32'(bus.mem_wdata), 'h3C);
    bus.wr_req = 1'b0; bus.vblank_only = 1'b0; p_tick = 1'b0;
    step();

    // Out-of-range handling and sticky error
    pixel_y = 10'd490;
    bus.wr_req = 1'b1; bus.wr_addr = 15'd19200; bus.wr_data = 8'h11;
    step();
    check("oor_ack", 32'({bus.wr_ack, bus.mem_en, bus.mem_we, bus.wr_err}), 'b1001);
    bus.wr_req = 1'b0;
    step();
    check("oor_sticky", 32'(bus.wr_err), 1);
    bus.err_clr = 1'b1;
    step();
    check("oor_clr", 32'(bus.wr_err), 0);
    bus.err_clr = 1'b0;
    bus.wr_req = 1'b1; bus.wr_addr = 15'd19199; bus.wr_data = 8'h77;
    step();
    check("last_ok", 32'({bus.wr_ack, bus.mem_we, bus.wr_err}), 'b110);
    check("last_addr", 32'(bus.mem_addr), 19199);
    bus.wr_req = 1'b0;
    step();
    bus.err_clr = 1'b1; bus.wr_req = 1'b1; bus.wr_addr = 15'd20000;
    step();
    check("clr_vs_set", 32'({bus.wr_ack, bus.wr_err}), 'b11);
    bus.err_clr = 1'b0; bus.wr_req = 1'b0;
    step();

    // Back-to-back writes in blanking with wr_req held high
    pixel_y = 10'd500;
    bus.wr_req = 1'b1; bus.wr_addr = a_tab[0]; bus.wr_data = d_tab[0];
    for (int i = 0; i < 3; i++) begin
      step();
      check("b2b_ack",   32'({bus.wr_ack, bus.mem_we}), 'b11);
      check("b2b_addr",  32'(bus.mem_addr), 32'(a_tab[i]));
      check("b2b_wdata", 32'(bus.mem_wdata), 32'(d_tab[i]));
      if (i < 2) begin
        bus.wr_addr = a_tab[i+1];
        bus.wr_data = d_tab[i+1];
      end else begin
        bus.wr_req = 1'b0;
      end
      step();
      check("b2b_gap", 32'({bus.wr_ack, bus.mem_en}), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port synchronous frame-buffer RAM between two users: the VGA scan-out path, driven by the 640x480 sync generator's outputs, and a pixel-writer client on a req/ack handshake.
- Scan-out always wins. Writes use the free RAM cycles.
- Produces pixel colour plus hsync/vsync/video_on, re-aligned to the RAM read latency.
- Sits between vga_sync, the frame-buffer RAM and the drawing engine or CPU bridge.

Parameters:
- H_DISP, 640, visible pixels per line.
- V_DISP, 480, visible lines per frame.
- SCALE_SHIFT, 2, log2 of the upscale factor. Frame buffer is (H_DISP>>SCALE_SHIFT) x (V_DISP>>SCALE_SHIFT) = 160x120.
- ADDR_W, 15, frame-buffer address width.
- DATA_W, 8, pixel width (RGB332).

Ports:
- clk  in  1  system clock (50 MHz).
- reset_n  in  1  asynchronous, active-low reset.
- p_tick  in  1  pixel enable from sync generator (every other clk).
- video_on_in  in  1  sync generator video_on.
- hsync_in  in  1  sync generator hsync.
- vsync_in  in  1  sync generator vsync.
- pixel_x  in  10  sync generator horizontal count.
- pixel_y  in  10  sync generator vertical count.
- wr_req  in  1  writer request; held high until wr_ack.
- wr_addr  in  ADDR_W  writer address; stable while wr_req is high.
- wr_data  in  DATA_W  writer data; stable while wr_req is high.
- wr_ack  out  1  one-cycle pulse: request consumed.
- wr_err  out  1  sticky: an out-of-range address was seen.
- err_clr  in  1  clears wr_err.
- vblank_only  in  1  when 1, writes are granted only during vertical blanking.
- mem_en  out  1  RAM enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data, valid 1 clk after mem_en with mem_we=0.
- rgb  out  DATA_W  pixel colour.
- hsync  out  1  re-aligned hsync.
- vsync  out  1  re-aligned vsync.
- video_on  out  1  re-aligned video_on.

Behaviour:
- Reset (asynchronous, reset_n=0) clears all registers: mem_en, mem_we, wr_ack, wr_err, rgb, hsync, vsync, video_on are all 0; mem_addr and mem_wdata are 0.
- Per-cycle arbitration, all RAM outputs registered. Grant states are RD, WR, IDLE, decided from the current-cycle inputs:
  - RD when p_tick && video_on_in.
  - Otherwise WR when wr_req && !wr_ack_reg && (!vblank_only || pixel_y >= V_DISP).
  - Otherwise IDLE (mem_en=0).
- Read address: ((pixel_y>>SCALE_SHIFT) * FB_W) + (pixel_x>>SCALE_SHIFT), where FB_W = H_DISP>>SCALE_SHIFT. Implement as shift-add (y*128 + y*32 for FB_W=160). The result is truncated to ADDR_W.
- Write grant drives mem_en=1, mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data in the next cycle. wr_ack pulses in that same cycle.
- The !wr_ack_reg term blocks re-granting a request that is being acked. A writer holding wr_req high one cycle after wr_ack is treated as a new request.
- Out-of-range write (wr_addr >= FB_W*FB_H = 19200): still acked, but mem_en and mem_we stay 0 and wr_err sets.
- wr_err clears only on err_clr. If err_clr and a new error occur in the same cycle, set wins.
- Scan-out latency is 2 clk from the RD grant cycle:
  - Grant cycle to registered mem_en: 1 clk.
  - RAM to mem_rdata: 1 clk; rgb is captured from mem_rdata in this cycle, one clk after mem_en.
- hsync_in, vsync_in and video_on_in pass through a 2-stage delay matched to that latency. rgb = 0 whenever the delayed video_on is 0.
- rgb holds its value on non-tick cycles, so each pixel is stable for 2 clk.
- Because p_tick alternates, at least every other cycle is available to the writer during active video. During blanking every cycle is available.
- Writer starvation with vblank_only=1 lasts at most one active frame (480 lines).
- Reset mid-transaction: the pending request is dropped without wr_ack. The writer must re-issue it after reset.

Decomposition:
- Shared package vga_pkg holds:
  - H_DISP, V_DISP, SCALE_SHIFT.
  - Derived FB_W, FB_H, FB_SIZE.
  - The pixel typedef (DATA_W-bit RGB332).
  - The grant enum {IDLE, RD, WR}.
- One natural sub-module, vga_fb_addr_gen: the combinational/registered x,y to address shift-add. The rest stays flat.

Test Plan:
- Reset: reset_n=0 mid-frame → all outputs 0 immediately (asynchronous). After release, first RD grant occurs on the first p_tick with video_on_in=1.
- Scan-out: RAM preloaded with addr[7:0]. At pixel_x=8, pixel_y=4 the address must be 1*160+2=162. rgb=0xA2 exactly 2 clk after the RD grant cycle, with hsync/vsync/video_on delayed by 2.
- Contention: wr_req held high during active video → grant lands only on p_tick=0 cycles, wr_ack is a single pulse, and mem_rdata-derived rgb is never corrupted.
- vblank_only=1, wr_req at pixel_y=100 → no ack until pixel_y=480. Then mem_we=1 with the given address and data, and wr_ack on the same cycle.
- Out-of-range: wr_addr=19200 → wr_ack=1, mem_we=0, wr_err=1. err_clr=1 → wr_err=0. err_clr together with a new error → wr_err stays 1.
- Back-to-back: wr_req held high across 3 writes during blanking → 3 acks on alternating cycles (request, ack, re-grant), and address and data are taken correctly for each write.
